// File: rtl/lib_pkg.sv
// rtl/lib_pkg.sv - opcode-class, ALU and comparator encodings shared by the core control path
package lib_pkg;

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_MISCMEM = 4'd9,
    OP_SYSTEM  = 4'd10
  } op_type_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SRA = 2'd2
  } alu_type_t;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BNE  = 3'b001,
    CMP_BLT  = 3'b100,
    CMP_BGE  = 3'b101,
    CMP_BLTU = 3'b110,
    CMP_BGEU = 3'b111
  } cmp_type_t;

endpackage

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RISC-V control FSM with bus timeout and retired counter
// Optional mul/div sequencing is enabled by defining RISCV_MULDIV_EN.
module mc_controller
  import lib_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  op_type_t         op_type,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             cmp_res,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             md_done,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_wr_en,
  output logic             ir_load,
  output logic             pc_wr_en,
  output logic             rf_wr_en,
  output logic             md_start,
  output logic             retired,
  output logic             sel_alu0,
  output logic             sel_alu1,
  output logic             sel_ex,
  output logic             sel_res,
  output logic             sel_rf_wr,
  output logic             sel_pc,
  output logic             sel_md,
  output alu_type_t        alu_type,
  output cmp_type_t        cmp_type,
  output logic [2:0]       state,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [6:0]      F7_ALT    = 7'b0100000;
  localparam logic [6:0]      F7_MD     = 7'b0000001;

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;
  logic              op_valid;
  logic              is_md;
  logic              is_lsu;
  logic              is_store;
  logic              is_ctrl;
  logic              is_jump;
  logic              wait_expired;

  assign op_valid = op_type inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                    OP_STORE, OP_OPIMM, OP_OP, OP_MISCMEM, OP_SYSTEM};
  assign is_md    = (op_type == OP_OP) && (funct7 == F7_MD);
  assign is_lsu   = op_type inside {OP_LOAD, OP_STORE};
  assign is_store = (op_type == OP_STORE);
  assign is_ctrl  = op_type inside {OP_BRANCH, OP_MISCMEM, OP_SYSTEM};
  assign is_jump  = op_type inside {OP_JAL, OP_JALR};

  // Ready is checked before this, so the last permitted request cycle still accepts ready.
  assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  assign state = st;

`ifndef RISCV_MULDIV_EN
  logic unused_md_done;
  assign unused_md_done = md_done;
`endif

  always_comb begin
    sel_alu0  = op_type inside {OP_AUIPC, OP_JAL, OP_BRANCH};
    sel_alu1  = !(op_type inside {OP_LUI, OP_OP, OP_MISCMEM, OP_SYSTEM});
    sel_ex    = (op_type == OP_LUI);
    sel_res   = !is_lsu;
    sel_rf_wr = is_jump;
  end

  always_comb begin
    alu_type = ALU_ADD;
    if ((op_type == OP_OP || op_type == OP_OPIMM) && funct7 == F7_ALT && funct3 == 3'b101)
      alu_type = ALU_SRA;
    else if (op_type == OP_OP && funct7 == F7_ALT && funct3 == 3'b000)
      alu_type = ALU_SUB;
  end

  always_comb begin
    cmp_type = CMP_BEQ;
    if (op_type == OP_BRANCH) begin
      case (funct3)
        3'b001:  cmp_type = CMP_BNE;
        3'b100:  cmp_type = CMP_BLT;
        3'b101:  cmp_type = CMP_BGE;
        3'b110:  cmp_type = CMP_BLTU;
        3'b111:  cmp_type = CMP_BGEU;
        default: cmp_type = CMP_BEQ;
      endcase
    end
  end

  // Strobes decode from the registered state so an async reset drops them immediately.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_wr_en = 1'b0;
    ir_load    = 1'b0;
    pc_wr_en   = 1'b0;
    rf_wr_en   = 1'b0;
    md_start   = 1'b0;
    sel_pc     = 1'b0;
    sel_md     = 1'b0;
    case (st)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_EXEC: begin
        if (is_ctrl) begin
          pc_wr_en = 1'b1;
          sel_pc   = (op_type == OP_BRANCH) && cmp_res;
        end
`ifdef RISCV_MULDIV_EN
        if (is_md) md_start = 1'b1;
`endif
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_wr_en = is_store;
        pc_wr_en   = is_store && dmem_ready;
      end
      S_WB: begin
        rf_wr_en = 1'b1;
        pc_wr_en = 1'b1;
        sel_pc   = is_jump;
      end
`ifdef RISCV_MULDIV_EN
      S_MULDIV: sel_md = 1'b1;
`endif
      default: ;
    endcase
  end

  assign retired = pc_wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
      instret  <= '0;
    end else begin
      if (retired) instret <= instret + CNT_W'(1);
      // Only a stalled FETCH/MEM keeps counting, so every entry into them starts from zero.
      wait_cnt <= '0;
      case (st)
        S_FETCH: begin
          if (imem_ready) begin
            st <= S_DECODE;
          end else if (wait_expired) begin
            st      <= S_ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
`ifdef RISCV_MULDIV_EN
          if (!op_valid) begin
`else
          if (!op_valid || is_md) begin
`endif
            st      <= S_ERR;
            bus_err <= 1'b1;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_lsu)
            st <= S_MEM;
          else if (is_ctrl)
            st <= S_FETCH;
`ifdef RISCV_MULDIV_EN
          else if (is_md)
            st <= S_MULDIV;
`endif
          else if (op_valid)
            st <= S_WB;
          else begin
            st      <= S_ERR;
            bus_err <= 1'b1;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            st <= is_store ? S_FETCH : S_WB;
          end else if (wait_expired) begin
            st      <= S_ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: st <= S_FETCH;
`ifdef RISCV_MULDIV_EN
        S_MULDIV: if (md_done) st <= S_WB;
`endif
        S_ERR: st <= S_ERR;
        default: begin
          st      <= S_ERR;
          bus_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller cycle traces, selects and timeouts
module tb_mc_controller;
  import lib_pkg::*;

  localparam int TO = 16;
  localparam int CW = 4;
`ifdef RISCV_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  localparam logic [9:0] B_IMEM = 10'h200, B_DMEM = 10'h100, B_DWR = 10'h080, B_IRL = 10'h040,
                         B_PCW  = 10'h020, B_RFW  = 10'h010, B_MDS = 10'h008, B_RET = 10'h004,
                         B_SPC  = 10'h002, B_SMD  = 10'h001;
  localparam logic [2:0] T_F = 3'd0, T_D = 3'd1, T_E = 3'd2, T_M = 3'd3, T_W = 3'd4,
                         T_MD = 3'd5, T_ERR = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  op_type_t op_type = OP_OP;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic cmp_res = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, md_done = 1'b0;
  logic imem_req, dmem_req, dmem_wr_en, ir_load, pc_wr_en, rf_wr_en, md_start, retired;
  logic sel_alu0, sel_alu1, sel_ex, sel_res, sel_rf_wr, sel_pc, sel_md;
  alu_type_t alu_type;
  cmp_type_t cmp_type;
  logic [2:0] state;
  logic bus_err;
  logic [CW-1:0] instret;
  logic [9:0] obs_sb;

  always #5 clk = ~clk;

  mc_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .op_type(op_type), .funct3(funct3), .funct7(funct7),
    .cmp_res(cmp_res), .imem_ready(imem_ready), .dmem_ready(dmem_ready), .md_done(md_done),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_wr_en(dmem_wr_en), .ir_load(ir_load),
    .pc_wr_en(pc_wr_en), .rf_wr_en(rf_wr_en), .md_start(md_start), .retired(retired),
    .sel_alu0(sel_alu0), .sel_alu1(sel_alu1), .sel_ex(sel_ex), .sel_res(sel_res),
    .sel_rf_wr(sel_rf_wr), .sel_pc(sel_pc), .sel_md(sel_md), .alu_type(alu_type),
    .cmp_type(cmp_type), .state(state), .bus_err(bus_err), .instret(instret)
  );

  assign obs_sb = {imem_req, dmem_req, dmem_wr_en, ir_load, pc_wr_en, rf_wr_en,
                   md_start, retired, sel_pc, sel_md};

  typedef struct {
    op_type_t      op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          cmp, ir, dr, md;
    logic [2:0]    st;
    logic [9:0]    sb;
    logic [CW-1:0] cnt;
    logic          berr;
  } rec_t;

  rec_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [CW-1:0] m_cnt = '0;
  op_type_t c_op;
  logic [2:0] c_f3;
  logic [6:0] c_f7;
  logic c_cmp;

  task automatic push(input logic ir, input logic dr, input logic md,
                      input logic [2:0] st, input logic [9:0] sb);
    rec_t r;
    r.op = c_op; r.f3 = c_f3; r.f7 = c_f7; r.cmp = c_cmp;
    r.ir = ir; r.dr = dr; r.md = md; r.st = st; r.sb = sb;
    r.cnt = m_cnt; r.berr = (st == T_ERR);
    sbq.push_back(r);
    if ((sb & B_RET) != 0) m_cnt = m_cnt + 1'b1;
  endtask

  // Expected cycle trace of one instruction: iw/dw/mw are stall cycles before each ready/done.
  task automatic plan(input op_type_t op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic cmp, input int iw, input int dw, input int mw);
    bit is_mul, valid;
    c_op = op; c_f3 = f3; c_f7 = f7; c_cmp = cmp;
    is_mul = (op == OP_OP) && (f7 == 7'b0000001);
    valid = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                       OP_OPIMM, OP_OP, OP_MISCMEM, OP_SYSTEM};
    for (int i = 0; i < iw; i++) push(0, 0, 0, T_F, B_IMEM);
    push(1, 0, 0, T_F, B_IMEM | B_IRL);
    push(0, 0, 0, T_D, '0);
    if (!valid || (is_mul && !MD)) begin
      for (int i = 0; i < 3; i++) push(0, 0, 0, T_ERR, '0);
    end else if (op inside {OP_BRANCH, OP_MISCMEM, OP_SYSTEM}) begin
      push(0, 0, 0, T_E, B_PCW | B_RET | ((op == OP_BRANCH && cmp) ? B_SPC : 10'h0));
    end else if (op inside {OP_LOAD, OP_STORE}) begin
      push(0, 0, 0, T_E, '0);
      for (int i = 0; i < dw; i++) push(0, 0, 0, T_M, B_DMEM | ((op == OP_STORE) ? B_DWR : 10'h0));
      if (op == OP_STORE) begin
        push(0, 1, 0, T_M, B_DMEM | B_DWR | B_PCW | B_RET);
      end else begin
        push(0, 1, 0, T_M, B_DMEM);
        push(0, 0, 0, T_W, B_RFW | B_PCW | B_RET);
      end
    end else if (is_mul) begin
      push(0, 0, 0, T_E, B_MDS);
      for (int i = 0; i < mw; i++) push(0, 0, 0, T_MD, B_SMD);
      push(0, 0, 1, T_MD, B_SMD);
      push(0, 0, 0, T_W, B_RFW | B_PCW | B_RET);
    end else begin
      push(0, 0, 0, T_E, '0);
      push(0, 0, 0, T_W, B_RFW | B_PCW | B_RET | ((op inside {OP_JAL, OP_JALR}) ? B_SPC : 10'h0));
    end
  endtask

  task automatic drain(input string tag);
    rec_t r;
    int cyc = 0;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      op_type = r.op; funct3 = r.f3; funct7 = r.f7; cmp_res = r.cmp;
      imem_ready = r.ir; dmem_ready = r.dr; md_done = r.md;
      @(negedge clk);
      n_cmp++;
      if (state !== r.st) begin
        n_err++;
        $display("FAIL %s cyc%0d state: got %0d want %0d", tag, cyc, state, r.st);
      end
      n_cmp++;
      if (obs_sb !== r.sb) begin
        n_err++;
        $display("FAIL %s cyc%0d strobes: got %b want %b", tag, cyc, obs_sb, r.sb);
      end
      n_cmp++;
      if (instret !== r.cnt || bus_err !== r.berr) begin
        n_err++;
        $display("FAIL %s cyc%0d instret/bus_err: got %0d/%b want %0d/%b",
                 tag, cyc, instret, bus_err, r.cnt, r.berr);
      end
      @(posedge clk); #1;
      cyc++;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0; md_done = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    m_cnt = '0;
    imem_ready = 1'b0; dmem_ready = 1'b0; md_done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (state !== T_F || obs_sb !== B_IMEM || instret !== '0 || bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: state=%0d strobes=%b instret=%0d bus_err=%b want 0/%b/0/0",
               state, obs_sb, instret, bus_err, B_IMEM);
    end
    do_reset();
  endtask

  task automatic test_selects;
    logic [4:0] tab [11];
    logic [4:0] got;
    tab[0] = 5'b00110; tab[1] = 5'b11010; tab[2] = 5'b11011; tab[3] = 5'b01011;
    tab[4] = 5'b11010; tab[5] = 5'b01000; tab[6] = 5'b01000; tab[7] = 5'b01010;
    tab[8] = 5'b00010; tab[9] = 5'b00010; tab[10] = 5'b00010;
    rst_n = 1'b0;
    funct3 = '0; funct7 = '0;
    for (int i = 0; i < 11; i++) begin
      op_type = op_type_t'(4'(i));
      #1;
      got = {sel_alu0, sel_alu1, sel_ex, sel_res, sel_rf_wr};
      n_cmp++;
      if (got !== tab[i]) begin
        n_err++;
        $display("FAIL selects op%0d: got %b want %b", i, got, tab[i]);
      end
    end
    op_type = OP_OP; funct3 = 3'b000; funct7 = 7'b0100000; #1;
    n_cmp++; if (alu_type !== ALU_SUB) begin n_err++; $display("FAIL alu sub: got %0d want %0d", alu_type, ALU_SUB); end
    funct7 = 7'b0000000; #1;
    n_cmp++; if (alu_type !== ALU_ADD) begin n_err++; $display("FAIL alu add: got %0d want %0d", alu_type, ALU_ADD); end
    funct3 = 3'b101; funct7 = 7'b0100000; #1;
    n_cmp++; if (alu_type !== ALU_SRA) begin n_err++; $display("FAIL alu sra: got %0d want %0d", alu_type, ALU_SRA); end
    op_type = OP_OPIMM; #1;
    n_cmp++; if (alu_type !== ALU_SRA) begin n_err++; $display("FAIL alu srai: got %0d want %0d", alu_type, ALU_SRA); end
    funct3 = 3'b000; #1;
    n_cmp++; if (alu_type !== ALU_ADD) begin n_err++; $display("FAIL alu addi: got %0d want %0d", alu_type, ALU_ADD); end
    op_type = OP_LOAD; funct3 = 3'b101; #1;
    n_cmp++; if (alu_type !== ALU_ADD) begin n_err++; $display("FAIL alu load: got %0d want %0d", alu_type, ALU_ADD); end
    op_type = OP_BRANCH; funct3 = 3'b001; #1;
    n_cmp++; if (cmp_type !== CMP_BNE) begin n_err++; $display("FAIL cmp bne: got %0d want %0d", cmp_type, CMP_BNE); end
    funct3 = 3'b110; #1;
    n_cmp++; if (cmp_type !== CMP_BLTU) begin n_err++; $display("FAIL cmp bltu: got %0d want %0d", cmp_type, CMP_BLTU); end
    op_type = OP_STORE; funct3 = 3'b001; #1;
    n_cmp++; if (cmp_type !== CMP_BEQ) begin n_err++; $display("FAIL cmp nonbranch: got %0d want %0d", cmp_type, CMP_BEQ); end
    do_reset();
  endtask

  task automatic test_alu;
    plan(OP_OP, 3'b000, 7'b0000000, 1'b0, 0, 0, 0);
    drain("add");
    n_cmp++;
    if (instret !== 4'd1) begin n_err++; $display("FAIL add instret: got %0d want 1", instret); end
  endtask

  task automatic test_load_wait;
    plan(OP_LOAD, 3'b010, 7'b0, 1'b0, 0, 3, 0);
    drain("load_wait");
  endtask

  task automatic test_branch;
    plan(OP_BRANCH, 3'b000, 7'b0, 1'b1, 0, 0, 0);
    plan(OP_BRANCH, 3'b000, 7'b0, 1'b0, 0, 0, 0);
    plan(OP_MISCMEM, 3'b000, 7'b0, 1'b1, 1, 0, 0);
    drain("branch");
  endtask

  task automatic test_store_jump;
    plan(OP_STORE, 3'b010, 7'b0, 1'b0, 2, 0, 0);
    plan(OP_JAL, 3'b000, 7'b0, 1'b0, 0, 0, 0);
    plan(OP_AUIPC, 3'b000, 7'b0, 1'b0, 15, 0, 0);
    drain("store_jump");
  endtask

  task automatic test_fetch_timeout;
    do_reset();
    c_op = OP_OP; c_f3 = '0; c_f7 = '0; c_cmp = 1'b0;
    for (int i = 0; i < TO; i++) push(0, 0, 0, T_F, B_IMEM);
    for (int i = 0; i < 4; i++) push(1, 1, 0, T_ERR, '0);
    drain("fetch_timeout");
    rst_n = 1'b0; #1;
    n_cmp++;
    if (bus_err !== 1'b0 || state !== T_F) begin
      n_err++; $display("FAIL err_clear: bus_err=%b state=%0d want 0/0", bus_err, state);
    end
    do_reset();
  endtask

  task automatic test_mem_timeout;
    do_reset();
    plan(OP_LOAD, 3'b010, 7'b0, 1'b0, 0, TO - 1, 0);
    c_op = OP_STORE;
    push(1, 0, 0, T_F, B_IMEM | B_IRL);
    push(0, 0, 0, T_D, '0);
    push(0, 0, 0, T_E, '0);
    for (int i = 0; i < TO; i++) push(0, 0, 0, T_M, B_DMEM | B_DWR);
    for (int i = 0; i < 3; i++) push(0, 1, 0, T_ERR, '0);
    drain("mem_timeout");
    do_reset();
  endtask

  task automatic test_decode_err;
    plan(op_type_t'(4'd13), 3'b000, 7'b0, 1'b0, 0, 0, 0);
    drain("decode_err");
    do_reset();
  endtask

  task automatic test_muldiv;
    plan(OP_OP, 3'b000, 7'b0000001, 1'b0, 0, 0, 4);
    drain("muldiv");
    do_reset();
    plan(OP_OP, 3'b000, 7'b0000001, 1'b0, 0, 0, 0);
    if (MD) plan(OP_OP, 3'b000, 7'b0, 1'b0, 0, 0, 0);
    drain("muldiv_first");
    do_reset();
  endtask

  task automatic test_instret_wrap;
    do_reset();
    for (int i = 0; i < 15; i++) plan(OP_BRANCH, 3'b001, 7'b0, i[0], 0, 0, 0);
    drain("wrap_fill");
    n_cmp++;
    if (instret !== 4'hF) begin n_err++; $display("FAIL wrap_full: got %0d want 15", instret); end
    plan(OP_SYSTEM, 3'b000, 7'b0, 1'b0, 0, 0, 0);
    drain("wrap_last");
    n_cmp++;
    if (instret !== 4'h0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", instret); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    op_type = OP_STORE; funct3 = 3'b010; funct7 = '0; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    imem_ready = 1'b0;
    n_cmp++;
    if (state !== T_M || dmem_wr_en !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: state=%0d dmem_wr_en=%b want 3/1", state, dmem_wr_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state !== T_F || obs_sb !== B_IMEM || instret !== '0) begin
      n_err++; $display("FAIL mid_reset: state=%0d strobes=%b instret=%0d want 0/%b/0", state, obs_sb, instret, B_IMEM);
    end
    do_reset();
  endtask

  task automatic test_back_to_back;
    do_reset();
    plan(OP_OP, 3'b000, 7'b0100000, 1'b0, 0, 0, 0);
    plan(OP_LOAD, 3'b000, 7'b0, 1'b0, 0, 1, 0);
    plan(OP_STORE, 3'b000, 7'b0, 1'b0, 0, 0, 0);
    plan(OP_BRANCH, 3'b100, 7'b0, 1'b1, 2, 0, 0);
    plan(OP_JALR, 3'b000, 7'b0, 1'b0, 0, 0, 0);
    plan(OP_LUI, 3'b000, 7'b0, 1'b0, 1, 0, 0);
    plan(OP_OPIMM, 3'b101, 7'b0100000, 1'b0, 0, 0, 0);
    drain("back_to_back");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_selects();
    test_alu();
    test_load_wait();
    test_branch();
    test_store_jump();
    test_fetch_timeout();
    test_mem_timeout();
    test_decode_err();
    test_muldiv();
    test_instret_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
